// File: rtl/cc_unit_if.sv
// cc_unit_if: bus between the execute stage, the condition-code unit and the
// memory stage.
//   master : upstream/downstream environment (drives in_*, hold_cc, flush, out_ready)
//   slave  : cc_unit (drives in_ready, out_*, cc_q)
// Signals:
//   in_valid/in_ready          execute-stage transfer handshake
//   icode, ifun, alu_s, flags  decoded instruction and adder result/flags
//   dst_e                      execute destination register, 4'hF = none
//   hold_cc, flush             downstream exception / squash controls
//   out_valid/out_ready        memory-stage handshake
//   out_icode, out_val,
//   out_dst_e, out_cnd         registered entry towards memory
//   cc_q                       architectural flags {ZF,SF,OF}
interface cc_unit_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       icode;
    logic [3:0]       ifun;
    logic [WIDTH-1:0] alu_s;
    logic             of_in;
    logic             zf_in;
    logic             sf_in;
    logic [3:0]       dst_e;
    logic             hold_cc;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       out_icode;
    logic [WIDTH-1:0] out_val;
    logic [3:0]       out_dst_e;
    logic             out_cnd;
    logic [2:0]       cc_q;

    modport master (
        output in_valid, icode, ifun, alu_s, of_in, zf_in, sf_in, dst_e,
               hold_cc, flush, out_ready,
        input  in_ready, out_valid, out_icode, out_val, out_dst_e, out_cnd, cc_q
    );

    modport slave (
        input  in_valid, icode, ifun, alu_s, of_in, zf_in, sf_in, dst_e,
               hold_cc, flush, out_ready,
        output in_ready, out_valid, out_icode, out_val, out_dst_e, out_cnd, cc_q
    );
endinterface

// File: rtl/cc_unit.sv
// cc_unit: Y86-64 execute-stage condition-code unit.
// Latches the adder flags into the CC register for OPq, evaluates the jXX /
// cmovXX condition against the CC state before the current instruction, and
// forwards icode, ALU result, (squashed) destination and condition through a
// one-entry registered valid/ready stage.
// Ports:
//   clk    pipeline clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    cc_unit_if.slave (handshakes, instruction fields, outputs, cc_q)
module cc_unit #(
    parameter int WIDTH = 64
) (
    input logic     clk,
    input logic     rst_n,
    cc_unit_if.slave bus
);
    localparam logic [3:0] IC_CMOV  = 4'h2;
    localparam logic [3:0] IC_OPQ   = 4'h6;
    localparam logic [3:0] IC_JXX   = 4'h7;
    localparam logic [3:0] IC_NOP   = 4'h1;
    localparam logic [3:0] REG_NONE = 4'hF;

    logic [2:0]       cc_q;
    logic             out_valid_q;
    logic [3:0]       out_icode_q;
    logic [WIDTH-1:0] out_val_q;
    logic [3:0]       out_dst_q;
    logic             out_cnd_q;

    logic             in_ready;
    logic             accept;
    logic             zf, sf, of, lt;
    logic             cond;
    logic             cnd;
    logic [3:0]       dst_sq;

    assign {zf, sf, of} = cc_q;
    assign lt           = sf ^ of;

    // Condition uses the flags as they stand before this instruction's update.
    always_comb begin
        cond = 1'b0;
        case (bus.ifun)
            4'h0:    cond = 1'b1;
            4'h1:    cond = lt | zf;
            4'h2:    cond = lt;
            4'h3:    cond = zf;
            4'h4:    cond = ~zf;
            4'h5:    cond = ~lt;
            4'h6:    cond = ~lt & ~zf;
            default: cond = 1'b0;
        endcase
    end

    assign cnd    = ((bus.icode == IC_JXX) || (bus.icode == IC_CMOV)) & cond;
    // A failed cmov must not write back, so its destination becomes "none".
    assign dst_sq = ((bus.icode == IC_CMOV) && !cnd) ? REG_NONE : bus.dst_e;

    // flush blocks input, so accept and flush never coincide.
    assign in_ready = ~bus.flush & (~out_valid_q | bus.out_ready);
    assign accept   = bus.in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc_q <= 3'b100;
        end else if (accept && (bus.icode == IC_OPQ) && !bus.hold_cc) begin
            cc_q <= {bus.zf_in, bus.sf_in, bus.of_in};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_icode_q <= IC_NOP;
            out_val_q   <= '0;
            out_dst_q   <= REG_NONE;
            out_cnd_q   <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_icode_q <= bus.icode;
            out_val_q   <= bus.alu_s;
            out_dst_q   <= dst_sq;
            out_cnd_q   <= cnd;
        end else if (bus.flush || bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_icode = out_icode_q;
    assign bus.out_val   = out_val_q;
    assign bus.out_dst_e = out_dst_q;
    assign bus.out_cnd   = out_cnd_q;
    assign bus.cc_q      = cc_q;
endmodule

// File: tb/tb_cc_unit.sv
// tb_cc_unit: directed bench for cc_unit with a scoreboard of expected output
// entries and a small model of cc_q / out_valid / in_ready.
module tb_cc_unit;
    logic clk;
    logic rst_n;

    cc_unit_if #(.WIDTH(64)) bus ();

    cc_unit #(.WIDTH(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0]  ic;
        logic [63:0] v;
        logic [3:0]  d;
        logic        c;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    exp_t        n;
    logic [2:0]  m_cc;
    logic        m_ov;
    logic        exp_ready;
    int          n_pass  = 0;
    int          n_total = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    function automatic logic model_cnd(input logic [3:0] ic, input logic [3:0] fn,
                                       input logic [2:0] cc);
        logic z, s, o;
        z = cc[2];
        s = cc[1];
        o = cc[0];
        if (ic != 4'h7 && ic != 4'h2) return 1'b0;
        case (fn)
            4'h0:    return 1'b1;
            4'h1:    return (s != o) || z;
            4'h2:    return (s != o);
            4'h3:    return z;
            4'h4:    return !z;
            4'h5:    return (s == o);
            4'h6:    return (s == o) && !z;
            default: return 1'b0;
        endcase
    endfunction

    // Scoreboard/model, evaluated 1 time unit before each rising edge.
    always @(negedge clk) begin
        #4;
        if (!rst_n) begin
            m_cc = 3'b100;
            m_ov = 1'b0;
            sb.delete();
        end else begin
            chk("out_valid_model", bus.out_valid, m_ov);
            chk("cc_q_model", bus.cc_q, m_cc);
            exp_ready = !bus.flush && (!m_ov || bus.out_ready);
            chk("in_ready_model", bus.in_ready, exp_ready);
            if (m_ov) begin
                chk("sb_nonempty", (sb.size() > 0), 1'b1);
                if (sb.size() > 0) begin
                    e = sb[0];
                    if (!bus.flush) begin
                        chk("sb_icode", bus.out_icode, e.ic);
                        chk("sb_val", bus.out_val, e.v);
                        chk("sb_dst", bus.out_dst_e, e.d);
                        chk("sb_cnd", bus.out_cnd, e.c);
                    end
                    if (bus.flush || bus.out_ready) void'(sb.pop_front());
                end
            end
            if (bus.flush) begin
                m_ov = 1'b0;
            end else if (bus.in_valid && exp_ready) begin
                n.ic = bus.icode;
                n.v  = bus.alu_s;
                n.c  = model_cnd(bus.icode, bus.ifun, m_cc);
                n.d  = (bus.icode == 4'h2 && !n.c) ? 4'hF : bus.dst_e;
                sb.push_back(n);
                m_ov = 1'b1;
                if (bus.icode == 4'h6 && !bus.hold_cc)
                    m_cc = {bus.zf_in, bus.sf_in, bus.of_in};
            end else if (bus.out_ready) begin
                m_ov = 1'b0;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] ic, input logic [3:0] fn,
                         input logic [63:0] s, input logic z, input logic sg,
                         input logic o, input logic [3:0] d, input logic h);
        bus.in_valid = v;
        bus.icode    = ic;
        bus.ifun     = fn;
        bus.alu_s    = s;
        bus.zf_in    = z;
        bus.sf_in    = sg;
        bus.of_in    = o;
        bus.dst_e    = d;
        bus.hold_cc  = h;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b0, 4'h1, 4'h0, 64'h0, 1'b0, 1'b0, 1'b0, 4'hF, 1'b0);
        repeat (2) tick();
        chk("rst_cc_q", bus.cc_q, 3'b100);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_icode", bus.out_icode, 4'h1);
        chk("rst_out_val", bus.out_val, 64'h0);
        chk("rst_out_dst_e", bus.out_dst_e, 4'hF);
        chk("rst_out_cnd", bus.out_cnd, 1'b0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", bus.in_ready, 1'b1);

        // je right after reset: Z=1
        drive(1'b1, 4'h7, 4'h3, 64'h0, 1'b0, 1'b0, 1'b0, 4'hF, 1'b0);
        tick();
        chk("je_valid", bus.out_valid, 1'b1);
        chk("je_cnd", bus.out_cnd, 1'b1);
        chk("je_icode", bus.out_icode, 4'h7);
        chk("je_cc_q", bus.cc_q, 3'b100);

        // OPq sets S, then jl / jg see the new flags
        drive(1'b1, 4'h6, 4'h0, 64'hA5A5_0000_1234_5678, 1'b0, 1'b1, 1'b0, 4'h2, 1'b0);
        tick();
        chk("opq_cc_q", bus.cc_q, 3'b010);
        chk("opq_val", bus.out_val, 64'hA5A5_0000_1234_5678);
        chk("opq_dst", bus.out_dst_e, 4'h2);
        drive(1'b1, 4'h7, 4'h2, 64'h10, 1'b0, 1'b0, 1'b0, 4'hF, 1'b0);
        tick();
        chk("jl_cnd", bus.out_cnd, 1'b1);
        drive(1'b1, 4'h7, 4'h6, 64'h11, 1'b0, 1'b0, 1'b0, 4'hF, 1'b0);
        tick();
        chk("jg_cnd", bus.out_cnd, 1'b0);

        // cmovne with Z=0 moves
        drive(1'b1, 4'h2, 4'h4, 64'h77, 1'b0, 1'b0, 1'b0, 4'h3, 1'b0);
        tick();
        chk("cmovne_z0_cnd", bus.out_cnd, 1'b1);
        chk("cmovne_z0_dst", bus.out_dst_e, 4'h3);

        // OPq sets Z, cmovne squashed
        drive(1'b1, 4'h6, 4'h1, 64'h0, 1'b1, 1'b0, 1'b0, 4'h5, 1'b0);
        tick();
        chk("opq_z_cc_q", bus.cc_q, 3'b100);
        drive(1'b1, 4'h2, 4'h4, 64'h88, 1'b0, 1'b0, 1'b0, 4'h3, 1'b0);
        tick();
        chk("cmovne_z1_cnd", bus.out_cnd, 1'b0);
        chk("cmovne_z1_dst", bus.out_dst_e, 4'hF);
        chk("cmovne_z1_val", bus.out_val, 64'h88);

        // OPq with hold_cc: entry passes, flags untouched
        drive(1'b1, 4'h6, 4'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1, 4'h4, 1'b1);
        tick();
        chk("hold_cc_q", bus.cc_q, 3'b100);
        chk("hold_valid", bus.out_valid, 1'b1);
        chk("hold_val", bus.out_val, 64'hFFFF_FFFF_FFFF_FFFF);

        // Backpressure for 3 cycles
        bus.out_ready = 1'b0;
        drive(1'b1, 4'h6, 4'h0, 64'h1234, 1'b0, 1'b1, 1'b1, 4'h6, 1'b0);
        repeat (3) begin
            tick();
            chk("bp_in_ready", bus.in_ready, 1'b0);
            chk("bp_val_stable", bus.out_val, 64'hFFFF_FFFF_FFFF_FFFF);
            chk("bp_cc_q", bus.cc_q, 3'b100);
        end
        bus.out_ready = 1'b1;
        tick();
        chk("rel_val", bus.out_val, 64'h1234);
        chk("rel_cc_q", bus.cc_q, 3'b011);
        drive(1'b1, 4'h7, 4'h5, 64'h5555, 1'b0, 1'b0, 1'b0, 4'hF, 1'b0);
        tick();
        chk("jge_val", bus.out_val, 64'h5555);
        chk("jge_cnd", bus.out_cnd, 1'b1);
        drive(1'b1, 4'h7, 4'h1, 64'h6666, 1'b0, 1'b0, 1'b0, 4'hF, 1'b0);
        tick();
        chk("jle_val", bus.out_val, 64'h6666);
        chk("jle_cnd", bus.out_cnd, 1'b0);

        // Flush while an entry is held
        bus.out_ready = 1'b0;
        bus.flush     = 1'b1;
        drive(1'b1, 4'h6, 4'h0, 64'h9, 1'b1, 1'b1, 1'b1, 4'h7, 1'b0);
        #1;
        chk("flush_in_ready", bus.in_ready, 1'b0);
        tick();
        chk("flush_valid", bus.out_valid, 1'b0);
        chk("flush_cc_q", bus.cc_q, 3'b011);
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b0, 4'h1, 4'h0, 64'h0, 1'b0, 1'b0, 1'b0, 4'hF, 1'b0);
        #1;
        chk("post_flush_ready", bus.in_ready, 1'b1);

        // Asynchronous reset mid-stream
        tick();
        drive(1'b1, 4'h6, 4'h0, 64'hDEAD, 1'b0, 1'b0, 1'b0, 4'h8, 1'b0);
        tick();
        chk("pre_rst_cc_q", bus.cc_q, 3'b000);
        chk("pre_rst_valid", bus.out_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", bus.out_valid, 1'b0);
        chk("async_rst_cc_q", bus.cc_q, 3'b100);
        chk("async_rst_val", bus.out_val, 64'h0);
        chk("async_rst_dst", bus.out_dst_e, 4'hF);
        drive(1'b0, 4'h1, 4'h0, 64'h0, 1'b0, 1'b0, 1'b0, 4'hF, 1'b0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("after_rst_ready", bus.in_ready, 1'b1);
        chk("after_rst_cc_q", bus.cc_q, 3'b100);
        drive(1'b1, 4'h7, 4'h3, 64'h42, 1'b0, 1'b0, 1'b0, 4'hF, 1'b0);
        tick();
        chk("after_rst_je", bus.out_cnd, 1'b1);
        drive(1'b0, 4'h1, 4'h0, 64'h0, 1'b0, 1'b0, 1'b0, 4'hF, 1'b0);
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/cc_unit.md
# cc_unit

Execute-stage condition-code unit for the Y86-64 pipeline. It sits directly downstream of the 64-bit ALU adder. It latches the adder's OF/ZF/SF into the architectural condition-code register when an OPq instruction retires through execute, and evaluates the branch/conditional-move condition for jXX and cmovXX. It forwards the ALU result, destination and condition to the memory stage through a one-entry registered valid/ready stage.

## Interface
Parameters:
- WIDTH, 64, data width of the ALU result carried through.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  execute-stage transfer offered.
- in_ready  output  1  unit can accept a transfer this cycle.
- icode  input  4  Y86 instruction code.
- ifun  input  4  Y86 function code.
- alu_s  input  WIDTH  adder sum S.
- of_in, zf_in, sf_in  input  1 each  adder flags OF, ZF, SF.
- dst_e  input  4  register ID for the execute result; 4'hF means none.
- hold_cc  input  1  exception pending downstream; suppresses the CC update.
- flush  input  1  squash the in-flight output entry and refuse input.
- out_valid  output  1  output entry valid.
- out_ready  input  1  memory stage accepts the entry.
- out_icode  output  4  registered icode.
- out_val  output  WIDTH  registered alu_s.
- out_dst_e  output  4  registered destination, after cmov squash.
- out_cnd  output  1  registered condition result.
- cc_q  output  3  architectural flags {ZF,SF,OF}.

## Operation
- Accept occurs when in_valid & in_ready. in_ready = ~flush & (~out_valid | out_ready).
- CC update: on accept with icode==4'h6 (OPq) and hold_cc==0, cc_q <= {zf_in,sf_in,of_in} at that edge. All other accepts leave cc_q unchanged.
- Condition evaluation uses cc_q as it stands in the accept cycle. This is the CC state before the current instruction. Let Z,S,O = cc_q bits and X = S^O:
  - ifun 0 (always): 1
  - ifun 1 (le): X|Z
  - ifun 2 (l): X
  - ifun 3 (e): Z
  - ifun 4 (ne): ~Z
  - ifun 5 (ge): ~X
  - ifun 6 (g): ~X&~Z
  - ifun 7..15: 0
- cnd is applied only when icode==4'h7 (jXX) or icode==4'h2 (rrmovq/cmovXX). For every other icode, cnd = 0.
- cmov squash: when icode==4'h2 and cnd==0, the registered out_dst_e = 4'hF. Otherwise out_dst_e = dst_e.
- Output register: on accept, capture icode, alu_s, the squashed dst_e and cnd, and set out_valid. When out_valid & out_ready with no new accept, clear out_valid. Data is held stable while out_valid & ~out_ready.
- flush: at the next edge out_valid <= 0. No accept occurs in a flush cycle. cc_q is not rolled back; updates from earlier edges stand.
- Width rule: alu_s passes through bit-exact. No arithmetic is performed in this block.

## Timing
- Reset (rst_n low, asynchronous):
  - cc_q = 3'b100 (Z=1, S=0, O=0).
  - out_valid = 0.
  - out_icode = 4'h1 (nop).
  - out_val = 0.
  - out_dst_e = 4'hF.
  - out_cnd = 0.
- Reset asserted mid-transfer discards the entry. in_ready is 1 in the first cycle after deassertion, unless flush is high.
- Latency: 1 cycle, from the accept edge to out_valid. Throughput is 1 per cycle while out_ready stays high.
- Back-to-back OPq then jXX: the OPq accepted at edge N updates cc_q at edge N. The jXX accepted at edge N+1 evaluates the new flags.
- OPq accepted together with hold_cc=1: the transfer passes to the output, and cc_q is unchanged.
- Backpressure: if out_valid=1 and out_ready=0, in_ready=0, and cc_q does not change (no accept).
- Simultaneous flush and out_ready: the entry is dropped, and out_valid becomes 0 at the next edge.

## Test plan
- Reset, then jXX ifun 3 (je) -> out_cnd=1 one cycle later (Z=1 at reset); cc_q=3'b100.
- OPq with zf_in=0, sf_in=1, of_in=0, then jXX ifun 2 (jl) on the next cycle -> cc_q=3'b010; jl out_cnd=1; a following jg (ifun 6) gives out_cnd=0.
- cmovXX ifun 4 (cmovne) with dst_e=4'h3 while Z=1 -> out_cnd=0 and out_dst_e=4'hF. With Z=0 -> out_cnd=1 and out_dst_e=4'h3.
- OPq with flags {1,0,1} and hold_cc=1 -> cc_q is unchanged; out_valid=1, and out_val equals alu_s (e.g. 64'hFFFF_FFFF_FFFF_FFFF).
- Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0; out_val is stable; cc_q is unchanged. Release -> one transfer per cycle resumes.
- Assert flush while out_valid=1, and assert rst_n low mid-stream -> out_valid=0 at the next edge (flush) or immediately (reset); after reset, cc_q=3'b100.
